// File: rtl/ext_dm_pkg.sv
// ext_dm_pkg: shared types for the external data-memory arbiter.
// FSM states, requester ids, read-tag record and default read latency.
package ext_dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam int MEM_RD_LAT_DEF = 3;

endpackage

// File: rtl/ext_dm_arbiter_if.sv
// ext_dm_arbiter_if: requester and memory-bus signals of the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface ext_dm_arbiter_if #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
);

  logic                req0;
  logic                req1;
  logic                wrb0;
  logic                wrb1;
  logic [DMA_SIZE-1:0] add0;
  logic [DMA_SIZE-1:0] add1;
  logic [DMD_SIZE-1:0] wdt0;
  logic [DMD_SIZE-1:0] wdt1;
  logic                lock0;
  logic                lock1;
  logic                gnt0;
  logic                gnt1;
  logic                rvalid0;
  logic                rvalid1;
  logic [DMD_SIZE-1:0] rdata;
  logic                mem_cslt;
  logic                mem_wrb;
  logic [DMA_SIZE-1:0] mem_add;
  logic [DMD_SIZE-1:0] mem_wdt;
  logic [DMD_SIZE-1:0] mem_rdt;

  modport slave (
    input  req0, req1, wrb0, wrb1,
    input  add0, add1, wdt0, wdt1,
    input  lock0, lock1, mem_rdt,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata, mem_cslt, mem_wrb,
    output mem_add, mem_wdt
  );

  modport master (
    output req0, req1, wrb0, wrb1,
    output add0, add1, wdt0, wdt1,
    output lock0, lock1, mem_rdt,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata, mem_cslt, mem_wrb,
    input  mem_add, mem_wdt
  );

endinterface

// File: rtl/ext_dm_rd_tag_pipe.sv
// ext_dm_rd_tag_pipe: shift register of read tags, one entry per cycle.
// Cleared asynchronously so in-flight reads vanish on reset.
module ext_dm_rd_tag_pipe
  import ext_dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] pipe_q;

  // shift a new tag in every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ext_dm_arbiter.sv
// ext_dm_arbiter: two-port arbiter/sequencer for memory_ext_2.
// EXT_DM_ARB_RR_EN selects round-robin; default is fixed priority.
module ext_dm_arbiter
  import ext_dm_pkg::*;
#(
  parameter int DMA_SIZE   = 3,
  parameter int DMD_SIZE   = 4,
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEF
) (
  input logic            clk,
  input logic            rst,
  ext_dm_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic                g0, g1;
  logic                cslt_q;
  logic                wrb_q;
  logic [DMA_SIZE-1:0] add_q;
  logic [DMD_SIZE-1:0] wdt_q;
  tag_t                tag_in, tag_out;

`ifdef EXT_DM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= ID0;
    else     ptr_q <= ptr_d;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // grant selection and next state; a dropped lock re-arbitrates at once
  always_comb begin
    state_d = state_q;
    g0      = 1'b0;
    g1      = 1'b0;
`ifdef EXT_DM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (rst) begin
      state_d = IDLE;
    end else if (state_q == OWN0 && bus.req0 && bus.lock0) begin
      g0 = 1'b1;
    end else if (state_q == OWN1 && bus.req1 && bus.lock1) begin
      g1 = 1'b1;
    end else begin
`ifdef EXT_DM_ARB_RR_EN
      if (bus.req0 && bus.req1) begin
        g0 = (ptr_q == ID0);
        g1 = (ptr_q == ID1);
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
`else
      g0 = bus.req0;
      g1 = bus.req1 & ~bus.req0;
`endif
      if (g0 && bus.lock0)      state_d = OWN0;
      else if (g1 && bus.lock1) state_d = OWN1;
      else                      state_d = IDLE;
    end
`ifdef EXT_DM_ARB_RR_EN
    if (g0)      ptr_d = ID1;
    else if (g1) ptr_d = ID0;
`endif
  end

  // register the winning command; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cslt_q <= 1'b0;
      wrb_q  <= 1'b0;
      add_q  <= '0;
      wdt_q  <= '0;
    end else begin
      cslt_q <= g0 | g1;
      unique case (1'b1)
        g0: begin
          wrb_q <= bus.wrb0;
          add_q <= bus.add0;
          wdt_q <= bus.wdt0;
        end
        g1: begin
          wrb_q <= bus.wrb1;
          add_q <= bus.add1;
          wdt_q <= bus.wdt1;
        end
        default: ;
      endcase
    end
  end

  // tag for this cycle: only granted reads are valid
  always_comb begin
    tag_in.valid = (g0 & ~bus.wrb0) | (g1 & ~bus.wrb1);
    tag_in.id    = g1 ? ID1 : ID0;
  end

  ext_dm_rd_tag_pipe #(
    .DEPTH(MEM_RD_LAT + 1)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  assign bus.gnt0     = g0;
  assign bus.gnt1     = g1;
  assign bus.rvalid0  = tag_out.valid & (tag_out.id == ID0);
  assign bus.rvalid1  = tag_out.valid & (tag_out.id == ID1);
  assign bus.rdata    = bus.mem_rdt;
  assign bus.mem_cslt = cslt_q;
  assign bus.mem_wrb  = wrb_q;
  assign bus.mem_add  = add_q;
  assign bus.mem_wdt  = wdt_q;

endmodule
